seq_divider: RTL and testbench

Sequential radix-2 restoring divider, the inverse-operation companion to the shift-add multiplier. Computes quotient and remainder of two D_SIZE-bit operands, one quotient bit per clock, under a start/busy/done handshake. Sits beside the multiplier in the arithmetic block and shares its clock, reset and start-pulse conventions.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_div_step.sv | 22 ++
 rtl/seq_divider.sv | 151 +++++++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared state encoding and arithmetic helper for the seq_divider block.
package seq_divider_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand must arrive sign-extended to 32 bits; the most-negative value maps onto itself.
  function automatic logic [31:0] twos_mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in one dividend bit, try subtracting the divisor.
// No state, no handshake; relies on rem_i < dvs_i so the kept remainder always fits D_SIZE bits.
module div_step #(
  parameter int D_SIZE = 8
) (
  input  logic [D_SIZE-1:0] rem_i,
  input  logic              bit_i,
  input  logic [D_SIZE-1:0] dvs_i,
  output logic [D_SIZE-1:0] rem_o,
  output logic              q_o
);

  logic [D_SIZE:0]   shifted;
  logic [D_SIZE+1:0] trial;

  assign shifted = {rem_i, bit_i};
  // Extra top bit acts as the borrow: set means the trial went negative.
  assign trial   = {1'b0, shifted} - {2'b00, dvs_i};
  assign q_o     = ~trial[D_SIZE+1];
  assign rem_o   = q_o ? D_SIZE'(trial) : D_SIZE'(shifted);

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock; done D_SIZE+1 edges after start (1 for B=0).
// strt_in is honoured only in IDLE; SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int D_SIZE = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              strt_in,
  input  logic [D_SIZE-1:0] A,
  input  logic [D_SIZE-1:0] B,
  output logic [D_SIZE-1:0] Q,
  output logic [D_SIZE-1:0] R,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(D_SIZE);

  state_t            state_q, state_d;
  logic [D_SIZE-1:0] rem_q, rem_d;
  logic [D_SIZE-1:0] dvd_q, dvd_d;
  logic [D_SIZE-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [D_SIZE-1:0] quo_q, quo_d;
  logic [D_SIZE-1:0] res_r_q, res_r_d;
  logic              dz_q, dz_d;

  logic              accept;
  logic [D_SIZE-1:0] op_a, op_b;
  logic [D_SIZE-1:0] step_rem;
  logic              step_qbit;
  logic [D_SIZE-1:0] quo_next;
  logic [D_SIZE-1:0] q_res, r_res;

  assign accept = (state_q == IDLE) && strt_in;

  div_step #(.D_SIZE(D_SIZE)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[D_SIZE-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_qbit)
  );

  // Dividend bits leave at the top while quotient bits fill in from the bottom.
  assign quo_next = {dvd_q[D_SIZE-2:0], step_qbit};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  assign op_a    = D_SIZE'(twos_mag(32'($signed(A))));
  assign op_b    = D_SIZE'(twos_mag(32'($signed(B))));
  assign neg_q_d = accept ? (A[D_SIZE-1] ^ B[D_SIZE-1]) : neg_q_q;
  assign neg_r_d = accept ? A[D_SIZE-1] : neg_r_q;
  assign q_res   = neg_q_q ? ({D_SIZE{1'b0}} - quo_next) : quo_next;
  assign r_res   = neg_r_q ? ({D_SIZE{1'b0}} - step_rem) : step_rem;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  assign op_a  = A;
  assign op_b  = B;
  assign q_res = quo_next;
  assign r_res = step_rem;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    res_r_d = res_r_q;
    dz_d    = dz_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (strt_in) begin
          rem_d = '0;
          dvd_d = op_a;
          dvs_d = op_b;
          cnt_d = CNT_W'(D_SIZE - 1);
          dz_d  = 1'b0;
          if (B == '0) begin
            state_d = DONE;
            quo_d   = '1;
            res_r_d = A;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        busy  = 1'b1;
        rem_d = step_rem;
        dvd_d = quo_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_res;
          res_r_d = r_res;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      res_r_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      res_r_q <= res_r_d;
      dz_q    <= dz_d;
    end
  end

  assign Q        = quo_q;
  assign R        = res_r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (D_SIZE=8): vector table, multi-cycle corner sequences, random vs model.
module tb_seq_divider;

  localparam int D = 8;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         strt_in;
  logic [D-1:0] A, B, Q, R;
  logic         busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  seq_divider #(.D_SIZE(D)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .strt_in  (strt_in),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain division on the operand values; returns {dz, q, r}.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa, sb, qi, ri;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sa == -128 && sb == -1) return {1'b0, 8'h80, 8'h00};
    qi = sa / sb;
    ri = sa % sb;
    return {1'b0, qi[7:0], ri[7:0]};
`else
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    return {1'b0, a / b, a % b};
`endif
  endfunction

  task automatic wait_done(inout int k, output bit seen);
    seen = 1'b0;
    while (k < 50 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk_in); #1;
        k++;
      end
    end
  endtask

  // Called 1ns after a posedge with the DUT idle; returns 1ns after the edge where it is idle again.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int k, nbusy, exp_lat;
    bit seen;
    A = a; B = b; strt_in = 1'b1;
    @(posedge clk_in); #1;
    strt_in = 1'b0;
    k = 0; nbusy = 0; seen = 1'b0;
    exp_lat = edz ? 0 : D;
    while (k < 50 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nbusy++;
        @(posedge clk_in); #1;
        k++;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, k, exp_lat);
    check({tag, " busy_cycles"}, nbusy, exp_lat);
    check({tag, " Q"}, 32'(Q), 32'(eq));
    check({tag, " R"}, 32'(R), 32'(er));
    check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
    @(posedge clk_in); #1;
    check({tag, " done_pulse_end"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    logic [16:0] m;
    logic [7:0]  ra, rb;
    int k, first, second;
    bit seen;

`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});
    tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
    tbl.push_back('{8'd55, 8'h00, 8'hFF, 8'd55, 1'b1});
    tbl.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
    tbl.push_back('{8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0});
    tbl.push_back('{8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0});
    tbl.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0});
`else
    tbl.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
    tbl.push_back('{8'd55, 8'd0, 8'hFF, 8'd55, 1'b1});
    tbl.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0});
    tbl.push_back('{8'd3, 8'd200, 8'd0, 8'd3, 1'b0});
    tbl.push_back('{8'd20, 8'd6, 8'd3, 8'd2, 1'b0});
    tbl.push_back('{8'd0, 8'd5, 8'd0, 8'd0, 1'b0});
    tbl.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0});
    tbl.push_back('{8'd128, 8'd3, 8'd42, 8'd2, 1'b0});
`endif

    rst_in = 1'b1; strt_in = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset outputs", {12'd0, Q, R, busy, done, div_zero}, 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("idle after reset", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < tbl.size(); i++)
      run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

    // strt_in held: 255/1 then 3/200, second done D+2 cycles after the first.
    A = 8'd255; B = 8'd1; strt_in = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 60 && second < 0; c++) begin
      @(posedge clk_in); #1;
      if (done) begin
        if (first < 0) begin
          first = c;
          check("b2b first Q", 32'(Q), 32'hFF);
          check("b2b first R", 32'(R), 32'h00);
          A = 8'd3; B = 8'd200;
        end else begin
          second = c;
          check("b2b second Q", 32'(Q), 32'h00);
          check("b2b second R", 32'(R), 32'h03);
        end
      end
    end
    strt_in = 1'b0;
    check("b2b first latency", first, D);
    check("b2b spacing", second - first, D + 2);
    repeat (2) @(posedge clk_in);
    #1;

    // Start ignored while running.
    A = 8'd100; B = 8'd7; strt_in = 1'b1;
    @(posedge clk_in); #1;
    strt_in = 1'b0;
    k = 0;
    repeat (3) begin @(posedge clk_in); #1; k++; end
    A = 8'd9; B = 8'd3; strt_in = 1'b1;
    @(posedge clk_in); #1; k++;
    strt_in = 1'b0;
    wait_done(k, seen);
    check("midrun done_seen", 32'(seen), 32'd1);
    check("midrun latency", k, D);
    check("midrun Q", 32'(Q), 32'd14);
    check("midrun R", 32'(R), 32'd2);
    repeat (2) @(posedge clk_in);
    #1;
    check("midrun not queued", {30'd0, busy, done}, 32'd0);

    // Asynchronous reset in the fourth RUN cycle.
    A = 8'd100; B = 8'd7; strt_in = 1'b1;
    @(posedge clk_in); #1;
    strt_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    check("async reset outputs", {12'd0, Q, R, busy, done, div_zero}, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("idle after midrun reset", {30'd0, busy, done}, 32'd0);
    run_div("after reset", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      m  = model(ra, rb);
      run_div($sformatf("rnd%0d a=%0h b=%0h", i, ra, rb), ra, rb, m[15:8], m[7:0], m[16]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
